// File: rtl/acq_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : acq_run_sequencer
// Brief   : Run controller for the FIR/averaging datapath: load pulse, sample
//           gating, transient skip, drain wait with timeout, host status.
// Revision: 1.0 - initial release
// ============================================================================
module acq_run_sequencer #(
  parameter int LOAD_CYCLES = 4,
  parameter int CNT_W       = 32,
  parameter int TIMEOUT     = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_samples,
  input  logic [CNT_W-1:0] n_skip,
  input  logic             src_valid,
  output logic             dp_reset_n,
  output logic             dp_enable,
  output logic             dp_in_valid,
  input  logic             dp_out_valid,
  output logic             sink_valid,
  output logic             busy,
  output logic             done,
  output logic             error_timeout,
  output logic [CNT_W-1:0] sample_count
);

  localparam int c_LOAD_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;
  localparam int c_IDLE_W = $clog2(TIMEOUT + 1);

  localparam logic [c_LOAD_W-1:0] c_LOAD_LAST = c_LOAD_W'(LOAD_CYCLES - 1);
  localparam logic [c_IDLE_W-1:0] c_TIMEOUT   = c_IDLE_W'(TIMEOUT);
  localparam logic [c_IDLE_W-1:0] c_IDLE_MAX  = '1;
  localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_LOAD  = 3'd1;
  localparam logic [2:0] c_RUN   = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic [CNT_W-1:0]    r_n_samples;
  logic [CNT_W-1:0]    r_n_skip;
  logic [CNT_W-1:0]    r_in_cnt;
  logic [CNT_W-1:0]    r_out_cnt;
  logic [c_IDLE_W-1:0] r_idle_cnt;
  logic [c_LOAD_W-1:0] r_load_cnt;

  logic                w_start_ok;
  logic                w_out_fire;
  logic                w_in_last;
  logic                w_out_reach;
  logic                w_timeout_exit;
  logic [CNT_W-1:0]    w_out_cnt_next;
  logic [c_IDLE_W-1:0] w_idle_inc;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; abort takes priority over every other transition
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_start_ok) w_state_next = c_LOAD;
      end
      c_LOAD: begin
        if (abort)                          w_state_next = c_IDLE;
        else if (r_load_cnt == c_LOAD_LAST) w_state_next = (r_n_samples == '0) ? c_DONE : c_RUN;
      end
      c_RUN: begin
        if (abort)          w_state_next = c_IDLE;
        else if (w_in_last) w_state_next = c_DRAIN;
      end
      c_DRAIN: begin
        if (abort)                            w_state_next = c_IDLE;
        else if (w_out_reach || w_timeout_exit) w_state_next = c_DONE;
      end
      c_DONE: begin
        if (w_start_ok) w_state_next = c_LOAD;
      end
      default: w_state_next = c_IDLE;
    endcase
  end

  // Output strobes and status decodes
  always_comb begin
    w_start_ok     = start && !abort && (r_state == c_IDLE || r_state == c_DONE);
    dp_in_valid    = src_valid && (r_state == c_RUN) && (r_in_cnt < r_n_samples);
    w_in_last      = dp_in_valid && (r_in_cnt == r_n_samples - c_CNT_ONE);
    w_out_fire     = dp_out_valid && (r_state == c_RUN || r_state == c_DRAIN);
    sink_valid     = w_out_fire && (r_out_cnt >= r_n_skip) && (r_out_cnt < r_n_samples);
    w_out_cnt_next = (w_out_fire && r_out_cnt != c_CNT_MAX) ? r_out_cnt + c_CNT_ONE : r_out_cnt;
    w_out_reach    = w_out_cnt_next >= r_n_samples;
    w_idle_inc     = (r_idle_cnt != c_IDLE_MAX) ? r_idle_cnt + c_IDLE_W'(1) : r_idle_cnt;
    w_timeout_exit = (r_state == c_DRAIN) && !abort && !w_out_reach && !dp_out_valid
                     && (w_idle_inc >= c_TIMEOUT);
  end

  // Registered outputs follow the upcoming state so they align with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_reset_n    <= 1'b0;
      dp_enable     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error_timeout <= 1'b0;
      sample_count  <= '0;
      r_n_samples   <= '0;
      r_n_skip      <= '0;
      r_in_cnt      <= '0;
      r_out_cnt     <= '0;
      r_idle_cnt    <= '0;
      r_load_cnt    <= '0;
    end else begin
      dp_reset_n <= (w_state_next != c_LOAD);
      dp_enable  <= (w_state_next == c_RUN) || (w_state_next == c_DRAIN);
      busy       <= (w_state_next == c_LOAD) || (w_state_next == c_RUN) || (w_state_next == c_DRAIN);
      done       <= (w_state_next == c_DONE);
      if (w_start_ok) begin
        r_n_samples   <= n_samples;
        r_n_skip      <= n_skip;
        r_in_cnt      <= '0;
        r_out_cnt     <= '0;
        r_idle_cnt    <= '0;
        r_load_cnt    <= '0;
        sample_count  <= '0;
        error_timeout <= 1'b0;
      end else begin
        if (r_state == c_LOAD && r_load_cnt != c_LOAD_LAST) r_load_cnt <= r_load_cnt + c_LOAD_W'(1);
        else                                                r_load_cnt <= '0;
        if (dp_in_valid && r_in_cnt != c_CNT_MAX) r_in_cnt <= r_in_cnt + c_CNT_ONE;
        r_out_cnt <= w_out_cnt_next;
        if (sink_valid && sample_count != c_CNT_MAX) sample_count <= sample_count + c_CNT_ONE;
        if (r_state == c_DRAIN && !dp_out_valid) r_idle_cnt <= w_idle_inc;
        else                                     r_idle_cnt <= '0;
        if (w_timeout_exit) error_timeout <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acq_run_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_acq_run_sequencer
// Brief   : Directed bench for acq_run_sequencer with a 3-cycle datapath model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_acq_run_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, abort, src_valid, dp_out_valid;
  logic [15:0] n_samples, n_skip, sample_count;
  logic        dp_reset_n, dp_enable, dp_in_valid, sink_valid, busy, done, error_timeout;

  int errors = 0;
  int checks = 0;
  int cyc;
  bit src_toggle;
  logic clr_cnt;

  acq_run_sequencer #(.LOAD_CYCLES(4), .CNT_W(16), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .n_samples(n_samples), .n_skip(n_skip), .src_valid(src_valid),
    .dp_reset_n(dp_reset_n), .dp_enable(dp_enable), .dp_in_valid(dp_in_valid),
    .dp_out_valid(dp_out_valid), .sink_valid(sink_valid), .busy(busy),
    .done(done), .error_timeout(error_timeout), .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  // Datapath: fixed 3-cycle latency, output count capped by out_limit
  logic [2:0] pipe;
  int emitted;
  int out_limit;
  always @(posedge clk) begin
    if (!dp_reset_n) begin
      pipe    <= '0;
      emitted <= 0;
    end else begin
      pipe <= {pipe[1:0], dp_in_valid};
      if (dp_out_valid) emitted <= emitted + 1;
    end
  end
  assign dp_out_valid = pipe[2] && (emitted < out_limit);

  int n_in, n_sink, n_en;
  always @(posedge clk) begin
    if (clr_cnt) begin
      n_in <= 0; n_sink <= 0; n_en <= 0;
    end else begin
      n_in   <= n_in + int'(dp_in_valid);
      n_sink <= n_sink + int'(sink_valid);
      n_en   <= n_en + int'(dp_enable);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (src_toggle) src_valid = ~src_valid;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_start(input logic [15:0] n, input logic [15:0] s);
    n_samples = n;
    n_skip    = s;
    start     = 1'b1;
    clr_cnt   = 1'b1;
    step();
    start     = 1'b0;
    clr_cnt   = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    while (!done && c < budget) begin
      step();
      c++;
    end
  endtask

  task automatic wait_in(input int n, input int budget);
    int c;
    c = 0;
    while (n_in < n && c < budget) begin
      step();
      c++;
    end
    check("wait_in_count", n_in, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0; src_toggle = 1'b0;
    n_samples = '0; n_skip = '0; out_limit = 1000; clr_cnt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {dp_reset_n, dp_enable, busy, done, error_timeout}, 5'b00000);
    check("rst_count", sample_count, 0);
    reset = 1'b0;
    step();
    check("idle_ctrl", {dp_reset_n, dp_enable, busy, done}, 4'b1000);

    // Load pulse timing followed by a normal run: n=8, skip=2
    src_toggle = 1'b1;
    run_start(16'd8, 16'd2);
    for (int i = 0; i < 4; i++) begin
      check("load_phase", {dp_reset_n, dp_enable, busy}, 3'b001);
      step();
    end
    check("run_phase", {dp_reset_n, dp_enable, busy}, 3'b111);
    wait_done(200, cyc);
    check("run_done", done, 1);
    check("run_in_strobes", n_in, 8);
    check("run_sink_strobes", n_sink, 6);
    check("run_sample_count", sample_count, 6);
    check("run_status", {error_timeout, busy, dp_enable}, 3'b000);

    // Drain timeout: only 3 of 5 outputs ever appear
    out_limit = 3;
    run_start(16'd5, 16'd0);
    wait_in(5, 100);
    wait_done(100, cyc);
    check("to_silent_cycles", cyc, 16);
    check("to_flags", {done, error_timeout, busy}, 3'b110);
    check("to_sample_count", sample_count, 3);
    out_limit = 1000;

    // Abort in RUN with a simultaneous start
    run_start(16'd8, 16'd0);
    wait_in(3, 60);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    check("abort_ctrl", {busy, dp_enable, done, error_timeout}, 4'b0000);
    repeat (3) step();
    check("abort_stays_idle", {busy, dp_enable, done, dp_reset_n}, 4'b0001);
    check("abort_sample_hold", sample_count, 2);
    check("abort_in_strobes", n_in, 3);

    // Zero-sample run goes LOAD -> DONE
    run_start(16'd0, 16'd0);
    repeat (3) step();
    check("zero_still_load", {done, busy}, 2'b01);
    step();
    check("zero_done", {done, busy, error_timeout}, 3'b100);
    check("zero_strobes", n_in + n_sink + n_en, 0);
    check("zero_sample_count", sample_count, 0);

    // Skip larger than sample count suppresses every output
    run_start(16'd4, 16'd10);
    wait_done(100, cyc);
    check("skip_done", done, 1);
    check("skip_in_strobes", n_in, 4);
    check("skip_sink", {16'(n_sink), sample_count}, 32'd0);

    // Async reset in DRAIN, then a fresh run
    run_start(16'd8, 16'd0);
    wait_in(8, 100);
    reset = 1'b1;
    #1;
    check("areset_ctrl", {dp_reset_n, dp_enable, busy, done, error_timeout}, 5'b00000);
    check("areset_count", sample_count, 0);
    @(posedge clk);
    #1;
    check("areset_held", {dp_reset_n, busy}, 2'b00);
    reset = 1'b0;
    step();
    run_start(16'd4, 16'd1);
    wait_done(100, cyc);
    check("fresh_done", {done, error_timeout}, 2'b10);
    check("fresh_sample_count", sample_count, 3);
    check("fresh_strobes", {16'(n_in), 16'(n_sink)}, {16'd4, 16'd3});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
